// File: rtl/nios_v1_cpu_mul_seq.sv
// Multiply sequencer around the 16x16 three-partial-product cell: one pass for mul,
// a second hi*hi pass plus sign correction for the mulx* high-word variants.
module nios_v1_cpu_mul_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [2:0]  dbg_state
);

   // Handshakes: a request transfers on a clk edge where req_valid & req_ready are both
   // high; a response transfers on an edge where rsp_valid & rsp_ready are both high.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P1   = 3'd1,
      S_C1   = 3'd2,
      S_P2   = 3'd3,
      S_C2   = 3'd4,
      S_DONE = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] s_hi_q, s_hi_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        req_ready_q;

   logic [32:0] mid;
   logic [63:0] s_pass1;
   logic [31:0] u_hi;
   logic [31:0] corr_a;
   logic [31:0] corr_b;
   logic [31:0] hi_word;

   // Pass-1 fold; only the upper half of s needs to survive into the second pass.
   assign mid     = {1'b0, cell_p2} + {1'b0, cell_p3};
   assign s_pass1 = {32'h0, cell_p1} + {15'h0, mid, 16'h0};

   assign u_hi    = s_hi_q + cell_p1;
   assign corr_a  = (op_q[1] && a_q[31]) ? b_q : 32'h0;
   assign corr_b  = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'h0;
   assign hi_word = u_hi - corr_a - corr_b;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      s_hi_d     = s_hi_q;
      rsp_data_d = rsp_data_q;
      cell_en    = 1'b0;
      cell_src1  = a_q;
      cell_src2  = b_q;
      rsp_valid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               a_d     = req_a;
               b_d     = req_b;
               op_d    = req_op;
               state_d = S_P1;
            end
         end
         S_P1: begin
            cell_en = 1'b1;
            state_d = S_C1;
         end
         S_C1: begin
            s_hi_d = s_pass1[63:32];
            if (op_q == 2'b00) begin
               rsp_data_d = s_pass1[31:0];
               state_d    = S_DONE;
            end else begin
               state_d = S_P2;
            end
         end
         S_P2: begin
            cell_src1 = {16'h0, a_q[31:16]};
            cell_src2 = {16'h0, b_q[31:16]};
            cell_en   = 1'b1;
            state_d   = S_C2;
         end
         S_C2: begin
            rsp_data_d = hi_word;
            state_d    = S_DONE;
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         a_q         <= 32'h0;
         b_q         <= 32'h0;
         op_q        <= 2'b00;
         s_hi_q      <= 32'h0;
         rsp_data_q  <= 32'h0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         s_hi_q      <= s_hi_d;
         rsp_data_q  <= rsp_data_d;
         // Registered so ready stays low until the first edge after reset release.
         req_ready_q <= (state_d == S_IDLE);
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_data  = rsp_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_nios_v1_cpu_mul_seq.sv
// Directed and randomized bench for nios_v1_cpu_mul_seq with a behavioural multiplier
// cell and a sign-extend-and-multiply reference model.
module tb_nios_v1_cpu_mul_seq;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] cell_src1;
   logic [31:0] cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1;
   logic [31:0] cell_p2;
   logic [31:0] cell_p3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [2:0]  dbg_state;

   int checks   = 0;
   int failures = 0;
   int last_wait;

   nios_v1_cpu_mul_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .cell_src1 (cell_src1),
      .cell_src2 (cell_src2),
      .cell_en   (cell_en),
      .cell_p1   (cell_p1),
      .cell_p2   (cell_p2),
      .cell_p3   (cell_p3),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier cell: one-cycle latency, outputs hold while M_en is low.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cell_p1 <= 32'h0;
         cell_p2 <= 32'h0;
         cell_p3 <= 32'h0;
      end else if (cell_en) begin
         cell_p1 <= cell_src1[15:0]  * cell_src2[15:0];
         cell_p2 <= cell_src1[15:0]  * cell_src2[31:16];
         cell_p3 <= cell_src1[31:16] * cell_src2[15:0];
      end
   end

   function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] ea, eb, prod;
      ea   = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
      eb   = ((op == 2'b11) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
      prod = ea * eb;
      return (op == 2'b00) ? prod[31:0] : prod[63:32];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Entered and left on a negedge. Latency is counted in edges from the accept edge
   // to the edge that first samples rsp_valid high.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input bit keep_valid,
                        input string tag);
      int n;
      logic [31:0] en_mask;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      last_wait = 0;
      while (!req_ready && last_wait < 50) begin
         @(negedge clk);
         last_wait++;
      end
      if (!req_ready) begin
         check({tag, "_accept_timeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ready_fall"}, {31'h0, req_ready}, 32'd0);
      if (!keep_valid) req_valid = 1'b0;
      req_a  = $urandom;
      req_b  = $urandom;
      req_op = 2'($urandom_range(0, 3));
      n       = 0;
      en_mask = 32'h0;
      while (!rsp_valid && n < 20) begin
         if (cell_en) en_mask[n] = 1'b1;
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin
         check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_latency"}, 32'(n + 1), (op == 2'b00) ? 32'd3 : 32'd5);
      check({tag, "_en_pattern"}, en_mask, (op == 2'b00) ? 32'h1 : 32'h5);
      check({tag, "_data"}, rsp_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'h0, rsp_valid}, 32'd1);
         check({tag, "_hold_data"}, rsp_data, exp);
         check({tag, "_hold_ready"}, {31'h0, req_ready}, 32'd0);
         check({tag, "_hold_en"}, {31'h0, cell_en}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_valid_fall"}, {31'h0, rsp_valid}, 32'd0);
      check({tag, "_ready_rise"}, {31'h0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      bit          saw_valid;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 32'h0;
      req_b     = 32'h0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'h0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_cell_en", {31'h0, cell_en}, 32'd0);
      check("rst_src1", cell_src1, 32'h0);
      check("rst_src2", cell_src2, 32'h0);
      rsp_ready = 1'b0;
      reset_n   = 1'b1;
      #1;
      check("rel_ready_low", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
      check("rel_ready_rise", {31'h0, req_ready}, 32'd1);

      do_op(2'b00, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 0, 1'b0, "mul_dir");
      do_op(2'b01, 32'h0001_2345, 32'h0001_0000, 32'h0000_0001, 0, 1'b0, "mulxuu_dir");
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, "mul_ones");
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0, "mulxuu_ones");
      do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulxsu_ones");
      do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, "mulxss_ones");
      do_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5, 1'b0, "bp_mulxss");

      // Abort a mulxuu during C1.
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_a     = 32'h1234_5678;
      req_b     = 32'h9ABC_DEF0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_req_ready", {31'h0, req_ready}, 32'd0);
      check("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("abort_rsp_data", rsp_data, 32'h0);
      check("abort_cell_en", {31'h0, cell_en}, 32'd0);
      check("abort_src1", cell_src1, 32'h0);
      check("abort_src2", cell_src2, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("abort_rel_ready_low", {31'h0, req_ready}, 32'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) saw_valid = 1'b1;
      end
      check("abort_no_rsp", {31'h0, saw_valid}, 32'd0);
      check("abort_ready_back", {31'h0, req_ready}, 32'd1);
      do_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, 0, 1'b0, "post_abort_mul");

      // Back-to-back with req_valid held high across requests.
      for (int i = 0; i < 4; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         do_op(rop, ra, rb, ref_model(rop, ra, rb), 0, 1'b1, $sformatf("b2b%0d", i));
         if (i > 0) check($sformatf("b2b%0d_accept_wait", i), 32'(last_wait), 32'd0);
      end
      req_valid = 1'b0;

      // Randomized operands and backpressure, including signed corner values.
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
         rb  = (i % 3 == 0) ? 32'h7FFF_FFFF : $urandom;
         do_op(rop, ra, rb, ref_model(rop, ra, rb), $urandom_range(0, 3), 1'b0,
               $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
